// File: rtl/rtc_wb_master_pkg.sv
// RTC Wishbone master: shared constants.
// Register map and controller state encoding.
package rtc_wb_master_pkg;

    localparam logic [2:0] CLOCK     = 3'd0;
    localparam logic [2:0] TIMER     = 3'd1;
    localparam logic [2:0] STOPWATCH = 3'd2;
    localparam logic [2:0] ALARM     = 3'd3;
    localparam logic [2:0] SPEED     = 3'd4;
    localparam logic [2:0] HACKTIME  = 3'd5;
    localparam logic [2:0] HACKHI    = 3'd6;
    localparam logic [2:0] HACKLO    = 3'd7;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HACK  = 3'd1,
        HWAIT = 3'd2,
        BUS   = 3'd3,
        RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/rtc_wb_master.sv
// RTC Wishbone master: single-command bus initiator
// with a hack-then-read-snapshot sequence.
module rtc_wb_master
    import rtc_wb_master_pkg::*;
#(
    parameter int LGTIMEOUT = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_stb,
    input  logic        i_cmd_we,
    input  logic [2:0]  i_cmd_addr,
    input  logic [31:0] i_cmd_data,
    input  logic [3:0]  i_cmd_sel,
    output logic        o_cmd_busy,
    input  logic        i_snap,
    output logic        o_hack,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [2:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_stall,
    input  logic        i_wb_ack,
    input  logic [31:0] i_wb_data,
    output logic        o_rsp_valid,
    output logic [2:0]  o_rsp_addr,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err
);

    localparam logic [LGTIMEOUT-1:0] TONE = 1;

    state_t               state;
    logic [LGTIMEOUT-1:0] tcnt;
    logic [LGTIMEOUT-1:0] tcnt_nxt;
    logic                 wcnt;
    logic                 snap;

    assign tcnt_nxt   = tcnt + TONE;
    assign o_cmd_busy = (state != IDLE);

    // Controller: accepts commands, runs the bus, reports results.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            tcnt        <= '0;
            wcnt        <= 1'b0;
            snap        <= 1'b0;
            o_hack      <= 1'b0;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_addr   <= '0;
            o_wb_data   <= '0;
            o_wb_sel    <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_addr  <= '0;
            o_rsp_data  <= '0;
            o_rsp_err   <= 1'b0;
        end else begin
            o_hack      <= 1'b0;
            o_rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_cmd_stb) begin
                        state     <= BUS;
                        snap      <= 1'b0;
                        tcnt      <= '0;
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        o_wb_we   <= i_cmd_we;
                        o_wb_addr <= i_cmd_addr;
                        o_wb_data <= i_cmd_data;
                        o_wb_sel  <= i_cmd_sel;
                    end else if (i_snap) begin
                        state  <= HACK;
                        o_hack <= 1'b1;
                    end
                end
                HACK: begin
                    state <= HWAIT;
                    wcnt  <= 1'b0;
                end
                HWAIT: begin
                    if (wcnt) begin
                        state     <= BUS;
                        snap      <= 1'b1;
                        tcnt      <= '0;
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        o_wb_we   <= 1'b0;
                        o_wb_addr <= HACKTIME;
                        o_wb_data <= '0;
                        o_wb_sel  <= 4'hF;
                    end else begin
                        wcnt <= 1'b1;
                    end
                end
                BUS: begin
                    if (o_wb_stb && !i_wb_stall)
                        o_wb_stb <= 1'b0;
                    if (i_wb_ack) begin
                        state       <= RESP;
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_addr  <= o_wb_addr;
                        o_rsp_err   <= 1'b0;
                        o_rsp_data  <= o_wb_we ? '0
                                               : i_wb_data;
                    end else if (&tcnt_nxt) begin
                        // Slave never answered: give up.
                        state       <= RESP;
                        tcnt        <= tcnt_nxt;
                        o_wb_cyc    <= 1'b0;
                        o_wb_stb    <= 1'b0;
                        o_rsp_valid <= 1'b1;
                        o_rsp_addr  <= o_wb_addr;
                        o_rsp_err   <= 1'b1;
                        o_rsp_data  <= '0;
                    end else begin
                        tcnt <= tcnt_nxt;
                    end
                end
                RESP: begin
                    if (snap && !o_rsp_err
                        && o_wb_addr != HACKLO) begin
                        state     <= BUS;
                        tcnt      <= '0;
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        o_wb_addr <= o_wb_addr + 3'd1;
                    end else begin
                        state <= IDLE;
                        snap  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_wb_master.sv
// Bench for rtc_wb_master: vector table,
// response scoreboard and snapshot/reset sequences.
module tb_rtc_wb_master;
    import rtc_wb_master_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_cmd_stb;
    logic        i_cmd_we;
    logic [2:0]  i_cmd_addr;
    logic [31:0] i_cmd_data;
    logic [3:0]  i_cmd_sel;
    logic        o_cmd_busy;
    logic        i_snap;
    logic        o_hack;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [2:0]  o_wb_addr;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_sel;
    logic        i_wb_stall;
    logic        i_wb_ack;
    logic [31:0] i_wb_data;
    logic        o_rsp_valid;
    logic [2:0]  o_rsp_addr;
    logic [31:0] o_rsp_data;
    logic        o_rsp_err;

    rtc_wb_master #(.LGTIMEOUT(4)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_cmd_stb  (i_cmd_stb),
        .i_cmd_we   (i_cmd_we),
        .i_cmd_addr (i_cmd_addr),
        .i_cmd_data (i_cmd_data),
        .i_cmd_sel  (i_cmd_sel),
        .o_cmd_busy (o_cmd_busy),
        .i_snap     (i_snap),
        .o_hack     (o_hack),
        .o_wb_cyc   (o_wb_cyc),
        .o_wb_stb   (o_wb_stb),
        .o_wb_we    (o_wb_we),
        .o_wb_addr  (o_wb_addr),
        .o_wb_data  (o_wb_data),
        .o_wb_sel   (o_wb_sel),
        .i_wb_stall (i_wb_stall),
        .i_wb_ack   (i_wb_ack),
        .i_wb_data  (i_wb_data),
        .o_rsp_valid(o_rsp_valid),
        .o_rsp_addr (o_rsp_addr),
        .o_rsp_data (o_rsp_data),
        .o_rsp_err  (o_rsp_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        we;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [3:0]  sel;
        int          stall;
        int          ackd;
        logic        noack;
        int          len;
    } vec_t;

    typedef struct {
        logic [2:0]  addr;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    vec_t  vecs[6];
    rsp_t  exp_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    logic [31:0] mem[8];
    int          cfg_stall = 0;
    int          cfg_ackd  = 1;
    logic [7:0]  cfg_noack = 8'h00;
    logic        acc_we;
    logic [2:0]  acc_addr;
    logic [31:0] acc_data;
    logic [3:0]  acc_sel;

    int   cyc_no   = 0;
    int   hack_cnt = 0;
    int   hack_at  = -1;
    int   rsp_cnt  = 0;
    int   cyc_run  = 0;
    int   last_len = 0;
    int   rise_at[$];
    int   rsp_at[$];

    function automatic void chk(string name,
                                logic [31:0] act,
                                logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h",
                     name, act, exp);
        end
    endfunction

    function automatic void push_exp(logic [2:0] a,
                                     logic [31:0] d,
                                     logic e);
        rsp_t r;
        r.addr = a;
        r.data = d;
        r.err  = e;
        exp_q.push_back(r);
    endfunction

    // Wishbone slave model: programmable stall / ack latency.
    initial begin : slave
        int sc;
        int ac;
        sc = 0;
        ac = -1;
        i_wb_stall = 1'b0;
        i_wb_ack   = 1'b0;
        i_wb_data  = '0;
        forever begin
            @(posedge i_clk);
            #1;
            i_wb_ack   = 1'b0;
            i_wb_stall = 1'b0;
            i_wb_data  = mem[o_wb_addr];
            if (!o_wb_cyc) begin
                sc = cfg_stall;
                ac = -1;
            end else if (o_wb_stb) begin
                if (sc > 0) begin
                    i_wb_stall = 1'b1;
                    sc--;
                end else begin
                    acc_we   = o_wb_we;
                    acc_addr = o_wb_addr;
                    acc_data = o_wb_data;
                    acc_sel  = o_wb_sel;
                    if (cfg_ackd == 0) begin
                        i_wb_ack = !cfg_noack[o_wb_addr];
                        ac = -1;
                    end else begin
                        ac = cfg_ackd;
                    end
                end
            end else if (ac > 0) begin
                ac--;
                if (ac == 0)
                    i_wb_ack = !cfg_noack[o_wb_addr];
            end
        end
    end

    // Monitor: scoreboard pops, cyc timing, stall stability.
    initial begin : monitor
        rsp_t        e;
        logic        p_cyc;
        logic        p_stb;
        logic        p_stall;
        logic        p_we;
        logic [2:0]  p_addr;
        logic [31:0] p_data;
        logic [3:0]  p_sel;
        p_cyc   = 1'b0;
        p_stb   = 1'b0;
        p_stall = 1'b0;
        p_we    = 1'b0;
        p_addr  = '0;
        p_data  = '0;
        p_sel   = '0;
        forever begin
            @(negedge i_clk);
            cyc_no++;
            if (o_hack) begin
                hack_cnt++;
                hack_at = cyc_no;
            end
            if (o_wb_cyc && !p_cyc)
                rise_at.push_back(cyc_no);
            if (o_wb_cyc) begin
                cyc_run++;
            end else if (p_cyc) begin
                last_len = cyc_run;
                cyc_run  = 0;
            end
            if (p_cyc && p_stb && p_stall && o_wb_cyc) begin
                chk("stall_stb", o_wb_stb, 1);
                chk("stall_we", o_wb_we, p_we);
                chk("stall_addr", o_wb_addr, p_addr);
                chk("stall_data", o_wb_data, p_data);
                chk("stall_sel", o_wb_sel, p_sel);
            end
            if (o_rsp_valid) begin
                rsp_cnt++;
                rsp_at.push_back(cyc_no);
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_addr", o_rsp_addr, e.addr);
                    chk("rsp_data", o_rsp_data, e.data);
                    chk("rsp_err", o_rsp_err, e.err);
                end
            end
            p_cyc   = o_wb_cyc;
            p_stb   = o_wb_stb;
            p_stall = i_wb_stall;
            p_we    = o_wb_we;
            p_addr  = o_wb_addr;
            p_data  = o_wb_data;
            p_sel   = o_wb_sel;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    task automatic wait_idle(input int lim);
        int k;
        k = 0;
        @(negedge i_clk);
        while (o_cmd_busy && k < lim) begin
            @(negedge i_clk);
            k++;
        end
        chk("idle_timeout", o_cmd_busy, 0);
    endtask

    task automatic run_vec(input vec_t v);
        logic [31:0] d;
        cfg_stall = v.stall;
        cfg_ackd  = v.ackd;
        cfg_noack = v.noack ? 8'hFF : 8'h00;
        d = (v.we || v.noack) ? 32'h0 : mem[v.addr];
        push_exp(v.addr, d, v.noack);
        @(posedge i_clk);
        #1;
        i_cmd_stb  = 1'b1;
        i_cmd_we   = v.we;
        i_cmd_addr = v.addr;
        i_cmd_data = v.data;
        i_cmd_sel  = v.sel;
        @(posedge i_clk);
        #1;
        i_cmd_stb = 1'b0;
        wait_idle(200);
        chk("cyc_len", last_len, v.len);
        if (!v.noack) begin
            chk("acc_we", acc_we, v.we);
            chk("acc_addr", acc_addr, v.addr);
            if (v.we) begin
                chk("acc_data", acc_data, v.data);
                chk("acc_sel", acc_sel, v.sel);
            end
        end
    endtask

    initial begin : main
        int h0;
        int r0;
        mem[0] = 32'hA5A5_0000;
        mem[1] = 32'h0000_0101;
        mem[2] = 32'h0000_0202;
        mem[3] = 32'hC0DE_0003;
        mem[4] = 32'h002A_F31E;
        mem[5] = 32'h0000_0011;
        mem[6] = 32'h0000_0022;
        mem[7] = 32'h0000_0033;

        vecs[0] = '{1'b1, CLOCK, 32'h0012_3456,
                    4'hF, 0, 1, 1'b0, 2};
        vecs[1] = '{1'b0, SPEED, 32'h0,
                    4'hF, 3, 2, 1'b0, 6};
        vecs[2] = '{1'b0, TIMER, 32'h0,
                    4'hF, 0, 1, 1'b1, 15};
        vecs[3] = '{1'b0, ALARM, 32'h0,
                    4'hF, 0, 0, 1'b0, 1};
        vecs[4] = '{1'b1, STOPWATCH, 32'hBEEF_CAFE,
                    4'h3, 1, 0, 1'b0, 2};
        vecs[5] = '{1'b0, CLOCK, 32'h0,
                    4'hF, 0, 3, 1'b0, 4};

        i_reset    = 1'b1;
        i_cmd_stb  = 1'b0;
        i_cmd_we   = 1'b0;
        i_cmd_addr = '0;
        i_cmd_data = '0;
        i_cmd_sel  = '0;
        i_snap     = 1'b0;

        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_cyc", o_wb_cyc, 0);
        chk("rst_stb", o_wb_stb, 0);
        chk("rst_we", o_wb_we, 0);
        chk("rst_hack", o_hack, 0);
        chk("rst_rsp_valid", o_rsp_valid, 0);
        chk("rst_rsp_err", o_rsp_err, 0);
        chk("rst_busy", o_cmd_busy, 0);
        chk("rst_rsp_addr", o_rsp_addr, 0);
        chk("rst_rsp_data", o_rsp_data, 0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        for (int i = 0; i < 6; i++)
            run_vec(vecs[i]);

        // Full snapshot: hack, two waits, reads 5/6/7.
        cfg_stall = 0;
        cfg_ackd  = 1;
        cfg_noack = 8'h00;
        push_exp(HACKTIME, 32'h11, 1'b0);
        push_exp(HACKHI, 32'h22, 1'b0);
        push_exp(HACKLO, 32'h33, 1'b0);
        h0 = hack_cnt;
        rise_at.delete();
        rsp_at.delete();
        @(posedge i_clk);
        #1;
        i_snap = 1'b1;
        @(posedge i_clk);
        #1;
        i_snap = 1'b0;
        wait_idle(300);
        chk("snap_hack_cnt", hack_cnt - h0, 1);
        chk("snap_rises", rise_at.size(), 3);
        chk("snap_rsps", rsp_at.size(), 3);
        if (rise_at.size() == 3 && rsp_at.size() == 3) begin
            chk("snap_hwait", rise_at[0] - hack_at, 3);
            for (int k = 0; k < 2; k++)
                chk("snap_next_cyc",
                    rise_at[k+1] - rsp_at[k], 1);
        end

        // Snapshot with a timeout on HACKHI aborts HACKLO.
        cfg_noack = 8'b0100_0000;
        push_exp(HACKTIME, 32'h11, 1'b0);
        push_exp(HACKHI, 32'h0, 1'b1);
        rise_at.delete();
        rsp_at.delete();
        @(posedge i_clk);
        #1;
        i_snap = 1'b1;
        @(posedge i_clk);
        #1;
        i_snap = 1'b0;
        wait_idle(300);
        chk("snap_to_rises", rise_at.size(), 2);
        chk("snap_to_rsps", rsp_at.size(), 2);

        // Command beats snap; reset mid-transaction.
        cfg_noack = 8'hFF;
        h0 = hack_cnt;
        r0 = rsp_cnt;
        @(posedge i_clk);
        #1;
        i_cmd_stb  = 1'b1;
        i_cmd_we   = 1'b0;
        i_cmd_addr = STOPWATCH;
        i_snap     = 1'b1;
        @(posedge i_clk);
        #1;
        i_cmd_stb = 1'b0;
        i_snap    = 1'b0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("pre_rst_cyc", o_wb_cyc, 1);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        chk("post_rst_cyc", o_wb_cyc, 0);
        chk("post_rst_busy", o_cmd_busy, 0);
        chk("post_rst_stb", o_wb_stb, 0);
        repeat (20) @(posedge i_clk);
        #1;
        chk("rst_no_hack", hack_cnt - h0, 0);
        chk("rst_no_rsp", rsp_cnt - r0, 0);
        chk("rst_idle_cyc", o_wb_cyc, 0);

        chk("exp_q_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
